// File: rtl/instr_fetch_unit.sv
// Fetch stage of the 8-bit accumulator CPU.
// Owns the program counter and runs a req/ack read of program memory.
// It latches the returned byte and holds it until the controller consumes it.
// A registered request bit splits FETCH into two phases: an idle cycle
// (req low) and a request phase (req high, waiting for ack).
module instr_fetch_unit #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 8,
  parameter int RESET_PC = 0,
  parameter int TIMEOUT  = 15
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_req,
  input  logic              mem_rd_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              instr_en,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_addr,
  input  logic              halt,
  output logic [DATA_W-1:0] instruction,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic              fetch_err
);

  typedef enum logic [1:0] {S_FETCH, S_HOLD, S_HALT} state_t;

  localparam logic [3:0] OP_HALT = 4'b1111;
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic [7:0] cnt;
  logic       timed_out;

  // The address comes straight from pc. pc only moves on ack or jump, and
  // both of those drop the request, so the address is stable while req is high.
  assign mem_addr  = pc;
  assign timed_out = mem_rd_req && !mem_rd_ack && (cnt == CNT_LAST);

  // Fetch state machine. Precedence is: halt, then time-out, then jump,
  // then ack/consume.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_FETCH;
      pc          <= ADDR_W'(RESET_PC);
      instruction <= '0;
      cnt         <= '0;
      mem_rd_req  <= 1'b0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
      fetch_err   <= 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          if (halt) begin
            state      <= S_HALT;
            mem_rd_req <= 1'b0;
            halted     <= 1'b1;
          end else if (timed_out) begin
            state      <= S_HALT;
            mem_rd_req <= 1'b0;
            halted     <= 1'b1;
            fetch_err  <= 1'b1;
          end else if (jump_en) begin
            // Any byte acked this cycle is dropped. The next cycle is idle.
            pc         <= jump_addr;
            cnt        <= '0;
            mem_rd_req <= 1'b0;
          end else if (!mem_rd_req) begin
            mem_rd_req <= 1'b1;
          end else if (mem_rd_ack) begin
            instruction <= mem_rdata;
            pc          <= pc + 1'b1;
            cnt         <= '0;
            mem_rd_req  <= 1'b0;
            instr_valid <= 1'b1;
            state       <= S_HOLD;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_HOLD: begin
          if (halt) begin
            state       <= S_HALT;
            instr_valid <= 1'b0;
            halted      <= 1'b1;
          end else if (jump_en) begin
            // A jump also consumes the held byte, so the opcode is not inspected.
            pc          <= jump_addr;
            instr_valid <= 1'b0;
            state       <= S_FETCH;
          end else if (instr_en) begin
            instr_valid <= 1'b0;
            if (instruction[DATA_W-1 -: 4] == OP_HALT) begin
              state  <= S_HALT;
              halted <= 1'b1;
            end else begin
              state      <= S_FETCH;
              mem_rd_req <= 1'b1;
            end
          end
        end
        default: begin
          // HALT is terminal. Only reset leaves it.
          mem_rd_req  <= 1'b0;
          instr_valid <= 1'b0;
          halted      <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit. It runs directed scenarios and then a
// randomized phase. Both are checked every cycle against a behavioural
// model of the fetch stage.
module tb_instr_fetch_unit;

  localparam int TO = 15;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] mem_addr;
  logic       mem_rd_req;
  logic       mem_rd_ack;
  logic [7:0] mem_rdata;
  logic       instr_en;
  logic       jump_en;
  logic [4:0] jump_addr;
  logic       halt;
  logic [7:0] instruction;
  logic       instr_valid;
  logic [4:0] pc;
  logic       halted;
  logic       fetch_err;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [32];

  // Model state, expressed in terms of what the outside world sees.
  int         m_pc;
  logic [7:0] m_instr;
  bit         m_req, m_have, m_stop, m_err;
  int         m_wait;

  instr_fetch_unit #(.ADDR_W(5), .DATA_W(8), .RESET_PC(0), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_rd_req(mem_rd_req),
    .mem_rd_ack(mem_rd_ack), .mem_rdata(mem_rdata), .instr_en(instr_en),
    .jump_en(jump_en), .jump_addr(jump_addr), .halt(halt),
    .instruction(instruction), .instr_valid(instr_valid), .pc(pc),
    .halted(halted), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_pc = 0; m_instr = 8'h00; m_req = 0; m_have = 0; m_stop = 0; m_err = 0; m_wait = 0;
  endtask

  // One clock of the reference behaviour, using the inputs applied before the edge.
  task automatic model_step(input bit ack, input bit en, input bit jmp, input int ja, input bit hlt);
    if (m_stop) return;
    if (hlt) begin
      m_stop = 1; m_have = 0; m_req = 0;
    end else if (!m_have) begin
      if (m_req && !ack && m_wait == TO - 1) begin
        m_err = 1; m_stop = 1; m_req = 0;
      end else if (jmp) begin
        m_pc = ja; m_req = 0; m_wait = 0;
      end else if (!m_req) begin
        m_req = 1;
      end else if (ack) begin
        m_instr = mem[m_pc]; m_pc = (m_pc + 1) % 32; m_wait = 0; m_req = 0; m_have = 1;
      end else begin
        m_wait++;
      end
    end else begin
      if (jmp) begin
        m_pc = ja; m_have = 0;
      end else if (en) begin
        m_have = 0;
        if (m_instr >= 8'hF0) m_stop = 1;
        else m_req = 1;
      end
    end
  endtask

  task automatic check(input string tag);
    logic [19:0] got, exp;
    got = {mem_rd_req, instr_valid, halted, fetch_err, pc, instruction, 3'b000};
    exp = {m_req, m_have, m_stop, m_err, 5'(m_pc), m_instr, 3'b000};
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got req/vld/hlt/err/pc/ins=%b/%b/%b/%b/%0d/%h exp %b/%b/%b/%b/%0d/%h",
             tag, got[19], got[18], got[17], got[16], got[15:11], got[10:3],
             exp[19], exp[18], exp[17], exp[16], exp[15:11], exp[10:3]);
    end
    if (m_req) begin
      checks++;
      assert (mem_addr === 5'(m_pc)) else begin
        errors++;
        $error("FAIL %s_addr: got %0d exp %0d", tag, mem_addr, m_pc);
      end
    end
  endtask

  task automatic cycle(input string tag, input bit ack, input bit en, input bit jmp,
                       input int ja, input bit hlt);
    mem_rd_ack = ack; instr_en = en; jump_en = jmp; jump_addr = 5'(ja); halt = hlt;
    mem_rdata  = mem[mem_addr];
    @(posedge clk);
    model_step(ack, en, jmp, ja, hlt);
    @(negedge clk);
    check(tag);
  endtask

  task automatic do_reset();
    mem_rd_ack = 0; instr_en = 0; jump_en = 0; jump_addr = 0; halt = 0; mem_rdata = 0;
    reset = 1'b0;
    model_reset();
    @(negedge clk); @(negedge clk);
    check("reset");
    reset = 1'b1;
  endtask

  task automatic expect_bit(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %b exp %b", tag, got, exp);
    end
  endtask

  task automatic expect_val(input string tag, input int got, input int exp);
    checks++;
    assert (got == exp) else begin
      errors++;
      $error("FAIL %s: got %0d exp %0d", tag, got, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 8'(i);
    mem[0] = 8'h12; mem[1] = 8'h23; mem[2] = 8'h45; mem[10] = 8'hF0;
    mem[20] = 8'h5A; mem[31] = 8'h31;

    // Reset, then the first fetch.
    do_reset();
    cycle("first_req", 0, 0, 0, 0, 0);
    expect_bit("first_req_bit", mem_rd_req, 1'b1);
    expect_val("first_addr", mem_addr, 0);
    cycle("first_ack", 1, 0, 0, 0, 0);
    expect_val("first_instr", instruction, 8'h12);
    expect_bit("first_valid", instr_valid, 1'b1);
    expect_val("first_pc", pc, 1);
    cycle("consume", 0, 1, 0, 0, 0);
    expect_val("second_addr", mem_addr, 1);

    // Stall in HOLD for five cycles.
    cycle("ack2", 1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cycle("stall", 0, 0, 0, 0, 0);
      expect_val("stall_instr", instruction, 8'h23);
      expect_bit("stall_req", mem_rd_req, 1'b0);
    end
    cycle("stall_release", 0, 1, 0, 0, 0);
    expect_bit("release_req", mem_rd_req, 1'b1);

    // Jump coinciding with ack: the fetched byte is dropped, then one idle cycle.
    cycle("jump_ack", 1, 0, 1, 20, 0);
    expect_bit("jump_valid", instr_valid, 1'b0);
    expect_val("jump_instr_kept", instruction, 8'h23);
    expect_bit("jump_idle", mem_rd_req, 1'b0);
    cycle("jump_req", 0, 0, 0, 0, 0);
    expect_val("jump_addr", mem_addr, 20);

    // Wrap from pc=31.
    cycle("to31", 0, 0, 1, 31, 0);
    cycle("idle31", 0, 0, 0, 0, 0);
    cycle("ack31", 1, 0, 0, 0, 0);
    expect_val("wrap_pc", pc, 0);
    expect_bit("wrap_err", fetch_err, 1'b0);

    // HALT opcode: a jump that coincides with consume skips the opcode check.
    cycle("jmp10", 0, 1, 1, 10, 0);
    cycle("idle10", 0, 0, 0, 0, 0);
    cycle("ackF0", 1, 0, 0, 0, 0);
    cycle("consumeF0", 0, 1, 0, 0, 0);
    expect_bit("halt_op", halted, 1'b1);
    for (int i = 0; i < 4; i++) cycle("halt_ignores", 1, 1, 1, 7, 0);
    expect_bit("halt_stays", halted, 1'b1);
    expect_val("halt_pc", pc, 11);
    do_reset();
    expect_val("reset_pc", pc, 0);

    // A halt input that coincides with ack drops the ack.
    cycle("h_idle", 0, 0, 0, 0, 0);
    cycle("h_ack", 1, 0, 0, 0, 1);
    expect_bit("h_ack_valid", instr_valid, 1'b0);
    expect_val("h_ack_pc", pc, 0);

    // Time-out, which beats a jump on its final cycle.
    do_reset();
    cycle("to_idle", 0, 0, 0, 0, 0);
    for (int i = 0; i < TO - 1; i++) cycle("to_wait", 0, 0, 0, 0, 0);
    expect_bit("to_not_yet", fetch_err, 1'b0);
    cycle("to_fire", 0, 0, 1, 3, 0);
    expect_bit("to_err", fetch_err, 1'b1);
    expect_bit("to_halted", halted, 1'b1);

    // Asynchronous reset in mid-FETCH, applied away from any clock edge.
    do_reset();
    cycle("ar_idle", 0, 0, 0, 0, 0);
    cycle("ar_wait", 0, 0, 0, 0, 0);
    reset = 1'b0;
    #1;
    expect_bit("ar_req", mem_rd_req, 1'b0);
    expect_bit("ar_halted", halted, 1'b0);
    expect_val("ar_pc", pc, 0);
    do_reset();

    // Randomized phase.
    for (int i = 0; i < 32; i++)
      mem[i] = ($urandom_range(0, 7) == 0) ? 8'hF0 | 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 239));
    for (int n = 0; n < 600; n++) begin
      if (m_stop && $urandom_range(0, 5) == 0) begin
        do_reset();
      end else begin
        cycle("rand",
              $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
              $urandom_range(0, 9) == 0, int'($urandom_range(0, 31)),
              $urandom_range(0, 79) == 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
